// File: rtl/logic_alu_pkg.sv
// Shared types for the logic_alu block.
// Opcode and FSM state encodings.
package logic_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_e;

endpackage

// File: rtl/logic_alu_if.sv
// Beat-in / result-out handshake bundle for logic_alu.
// slave = the ALU side, master = the driver/consumer side.
interface logic_alu_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_last, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_parity,
        output out_count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_last, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_parity,
        input  out_count
    );
endinterface

// File: rtl/logic_alu_op.sv
// Bitwise function unit for logic_alu.
// Inverted ops are applied as a plain ~(x op y).
module logic_op
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  op_e              op,
    output logic [WIDTH-1:0] r
);

    // Select the bitwise result for the opcode.
    always_comb begin
        r = '0;
        unique case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_NAND: r = ~(x & y);
            OP_NOR:  r = ~(x | y);
            OP_XNOR: r = ~(x ^ y);
            OP_ANDN: r = x & ~y;
            OP_PASS: r = x;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/logic_alu.sv
// Packet-folding bitwise ALU: beats fold into one result,
// held until consumed, with zero/parity/beat-count flags.
module logic_alu
    import logic_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    logic_alu_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             zero_q, zero_d;
    logic             par_q, par_d;

    logic             in_rdy;
    logic             fire;
    logic             first;
    logic [WIDTH-1:0] f_x, f_y, f_r;
    op_e              f_op;

    // A held result blocks new beats unless it drains this cycle.
    assign in_rdy = !rst && ((state_q != S_OUT) || bus.out_ready);
    assign fire   = bus.in_valid && in_rdy;
    // Any beat outside an open packet starts a new one.
    assign first  = (state_q != S_ACCUM);

    // First beat combines a with b; later beats fold a into acc.
    always_comb begin
        f_x  = bus.in_a;
        f_y  = bus.in_b;
        f_op = op_e'(bus.in_op);
        if (!first) begin
            f_x  = acc_q;
            f_y  = bus.in_a;
            f_op = op_q;
        end
    end

    logic_op #(
        .WIDTH (WIDTH)
    ) u_op (
        .x  (f_x),
        .y  (f_y),
        .op (f_op),
        .r  (f_r)
    );

    // Next-state, accumulator, count and flag computation.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        par_d   = par_q;
        if (fire) begin
            acc_d  = f_r;
            zero_d = (f_r == '0);
            par_d  = ^f_r;
            if (first) begin
                op_d  = op_e'(bus.in_op);
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = bus.in_last ? S_OUT : S_ACCUM;
        end else if (state_q == S_OUT && bus.out_ready) begin
            state_d = S_IDLE;
        end
        valid_d = (state_d == S_OUT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = valid_q;
    assign bus.out_y      = acc_q;
    assign bus.out_zero   = zero_q;
    assign bus.out_parity = par_q;
    assign bus.out_count  = cnt_q;

endmodule

// File: doc/logic_alu.md
LOGIC_ALU -- requirements
Module: logic_alu

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 4, width of the beat counter output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input beat offered.
REQ-006 in_ready  output  1  input beat accepted when in_valid && in_ready at a clk edge.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B (used on the first beat of a packet only).
REQ-009 in_op  input  3  opcode (used on the first beat of a packet only).
REQ-010 in_last  input  1  marks the final beat of a packet.
REQ-011 out_valid  output  1  result held and offered.
REQ-012 out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-013 out_y  output  WIDTH  packet result.
REQ-014 out_zero  output  1  high when out_y == 0.
REQ-015 out_parity  output  1  XOR-reduction of out_y.
REQ-016 out_count  output  CNT_W  number of beats in the packet, saturating.

Function
REQ-017 Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS (a); all bitwise over WIDTH.
REQ-018 A packet is 1..N beats; a single beat with in_last=1 is a complete packet.
REQ-019 First accepted beat: acc <= f(in_a, in_b); op latched; count <= 1.
REQ-020 Subsequent beats: acc <= f_latched(acc, in_a); in_op and in_b ignored; count increments, saturating at 2^CNT_W-1.
REQ-021 NAND/NOR/XNOR fold as f(x,y) = ~(x op y) applied each beat, with no special-casing.
REQ-022 States: IDLE (no packet, output empty), ACCUM (packet open), OUT (result held).
REQ-023 IDLE: accepted beat with in_last goes to OUT; without in_last goes to ACCUM.
REQ-024 ACCUM: accepted beat with in_last goes to OUT; otherwise stays in ACCUM.
REQ-025 OUT: on consume with no accept, go to IDLE; on consume with a simultaneous accept, go to OUT if in_last, else ACCUM.
REQ-026 in_ready = (state != OUT) || out_ready; forced 0 while rst is high.
REQ-027 Latency: out_valid rises on the cycle after the last beat is accepted; back-to-back single-beat packets sustain 1 result/cycle.
REQ-028 out_y, out_zero, out_parity and out_count are registered and stay stable while out_valid && !out_ready.
REQ-029 out_zero, out_parity and out_count are valid only while out_valid=1.
REQ-030 in_valid=0 in ACCUM leaves state unchanged indefinitely.

Reset
REQ-031 On rst: state IDLE, out_valid=0, in_ready=0, acc=0, out_y=0, out_zero=0, out_parity=0, out_count=0, latched op=0.
REQ-032 Reset mid-packet or with a result pending discards all data; no output is produced for the discarded packet.
REQ-033 in_ready=1 on the first cycle after rst deasserts.

Structure
REQ-034 Package logic_alu_pkg SHALL hold the opcode enum (3-bit) and the state enum.
REQ-035 Sub-module logic_op (combinational, WIDTH-parametrised, inputs x, y, op; output r) SHALL implement f; logic_alu instantiates one copy.

Verification
REQ-036 WIDTH=1, op AND, single beats a/b = 00, 01, 10, 11 -> out_y = 0, 0, 0, 1, each one cycle after accept, out_count=1.
REQ-037 WIDTH=8, single beat a=0xF0, b=0x3C, op XOR -> out_y=0xCC, out_zero=0, out_parity=0, out_count=1.
REQ-038 Fold AND, beats (a=0xFF, b=0x0F), a=0x3C, a=0x0C with in_last -> out_y=0x0C, out_count=3; in_op changes on beats 2-3 are ignored.
REQ-039 Result held with out_ready=0 for 5 cycles -> in_ready=0 and out_y stable; then out_ready=1 with a new single-beat packet (in_valid=1) -> both transfers complete in the same cycle, new result on the next cycle.
REQ-040 Two OR beats, then rst for 1 cycle, then single-beat NAND a=0xFF, b=0xFF -> no stale output; out_y=0x00, out_zero=1, out_count=1.
REQ-041 CNT_W=2, 5-beat XOR packet of a=0x01 -> out_count=3 (saturated).
